mult_result_checker: RTL and testbench



---
 rtl/mult_result_checker_pkg.sv | 21 ++
 rtl/mult_result_checker_if.sv | 30 +++
 rtl/mult_result_checker_sat_counter.sv | 28 ++
 rtl/mult_result_checker.sv | 153 +++++++++++++++
 tb/tb_mult_result_checker.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_result_checker_pkg.sv
// ---------------------------------------------------------------------------
// mult_result_checker_pkg
// Shared definitions for the multiplier result checker. The state encoding is
// exported as plain localparams so the test control unit can decode the
// checker state in its status register using exactly the same values.
// ---------------------------------------------------------------------------
package mult_result_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } chk_state_t;

endpackage

// File: rtl/mult_result_checker_if.sv
// ---------------------------------------------------------------------------
// mult_result_checker_if
// Product stream from the multiplier pipeline plus the golden RAM read port.
//   in_valid   product valid (delayed write enable)
//   in_addr    vector address of in_prod
//   in_prod    product word
//   gold_addr  golden RAM read address (driven by the checker)
//   gold_q     golden RAM data, registered, 1-cycle read latency
// master: pipeline / golden RAM side.  slave: the checker.
// ---------------------------------------------------------------------------
interface mult_result_checker_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int PROD_WIDTH = 63
);
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [PROD_WIDTH-1:0] in_prod;
    logic [ADDR_WIDTH-1:0] gold_addr;
    logic [PROD_WIDTH-1:0] gold_q;

    modport master (
        output in_valid, in_addr, in_prod, gold_q,
        input  gold_addr
    );

    modport slave (
        input  in_valid, in_addr, in_prod, gold_q,
        output gold_addr
    );
endinterface

// File: rtl/mult_result_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// mult_result_checker_sat_counter (sat_counter)
// Up-counter that sticks at all ones instead of wrapping.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   clr    synchronous clear (wins over inc)
//   inc    increment by one unless already saturated
//   count  current value
// ---------------------------------------------------------------------------
module mult_result_checker_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mult_result_checker.sv
// ---------------------------------------------------------------------------
// mult_result_checker
// Compares each product from the multiplier pipeline bit-exactly against a
// preloaded golden RAM, counts mismatches, captures the first failure and
// reports completion or watchdog timeout.
//   pll_clk, resetn      clock and synchronous active-low reset
//   start                1-cycle pulse: clear results, begin run (IDLE/DONE only)
//   n_vectors            products expected this run, latched on accepted start
//   res                  product stream + golden RAM port (slave)
//   busy                 high in RUN or FLUSH
//   done                 high in DONE, held until next start
//   timeout              run aborted by watchdog; valid while done
//   err_count            saturating mismatch count for this run
//   first_err_*          address/product/golden word of the first mismatch
// ---------------------------------------------------------------------------
module mult_result_checker
    import mult_result_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int PROD_WIDTH = 63,
    parameter int ERR_WIDTH  = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  pll_clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_vectors,
    mult_result_checker_if.slave  res,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [PROD_WIDTH-1:0] first_err_prod,
    output logic [PROD_WIDTH-1:0] first_err_gold
);
    localparam int WD_WIDTH = $clog2(TIMEOUT);

    chk_state_t            state, state_next;
    logic [ADDR_WIDTH:0]   n_vec_q;
    logic [ADDR_WIDTH:0]   acc_count;
    logic [WD_WIDTH-1:0]   wd_count;

    logic                  cmp_valid;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [PROD_WIDTH-1:0] cmp_prod;

    logic start_ok, accept, all_in, wd_expire, mismatch;

    // Golden RAM is addressed straight from the stream so its registered
    // output lines up with stage 1 one cycle later.
    assign res.gold_addr = res.in_addr;

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign accept    = res.in_valid && (state == RUN) && (acc_count < n_vec_q);
    // Count reached: either this accept is the last one, or nothing was
    // expected at all (n_vectors == 0).
    assign all_in    = (state == RUN) &&
                       (accept ? ((acc_count + 1'b1) == n_vec_q) : (acc_count == n_vec_q));
    assign wd_expire = (state == RUN) && !accept && (wd_count == WD_WIDTH'(TIMEOUT - 1));
    assign mismatch  = cmp_valid && ((state == RUN) || (state == FLUSH)) &&
                       (cmp_prod != res.gold_q);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge pll_clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (all_in || wd_expire) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run control, watchdog and first-error capture.
    always_ff @(posedge pll_clk) begin
        if (!resetn) begin
            n_vec_q         <= '0;
            acc_count       <= '0;
            wd_count        <= '0;
            timeout         <= 1'b0;
            cmp_valid       <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_prod  <= '0;
            first_err_gold  <= '0;
        end else begin
            cmp_valid <= accept;
            if (start_ok) begin
                n_vec_q         <= n_vectors;
                acc_count       <= '0;
                wd_count        <= '0;
                timeout         <= 1'b0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
                first_err_prod  <= '0;
                first_err_gold  <= '0;
            end else begin
                if (accept) acc_count <= acc_count + 1'b1;
                // Watchdog restarts on every accept and only advances in RUN.
                if (accept || (state != RUN)) wd_count <= '0;
                else                          wd_count <= wd_count + 1'b1;
                if (wd_expire && !all_in) timeout <= 1'b1;
                if (mismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_addr;
                    first_err_prod  <= cmp_prod;
                    first_err_gold  <= res.gold_q;
                end
            end
        end
    end

    // NOTE: pure datapath registers are qualified by cmp_valid, so they need
    // no reset and are kept out of the reset tree.
    always_ff @(posedge pll_clk) begin
        cmp_addr <= res.in_addr;
        cmp_prod <= res.in_prod;
    end

    mult_result_checker_sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_sat_counter (
        .clk   (pll_clk),
        .rst_n (resetn),
        .clr   (start_ok),
        .inc   (mismatch),
        .count (err_count)
    );
endmodule

// File: tb/tb_mult_result_checker.sv
// ---------------------------------------------------------------------------
// tb_mult_result_checker
// Two checkers (ERR_WIDTH 16 and 2, TIMEOUT 16) see identical stimulus; each
// has its own golden RAM model. Table-driven runs plus hand-written sequences
// for mid-run start, n_vectors==0, watchdog timeout and mid-run reset.
// ---------------------------------------------------------------------------
module tb_mult_result_checker;
    localparam int AW   = 9;
    localparam int PW   = 63;
    localparam int EW_A = 16;
    localparam int EW_B = 2;
    localparam int TO   = 16;

    logic          pll_clk;
    logic          resetn;
    logic          start;
    logic [AW:0]   n_vectors;

    logic          busy_a, done_a, to_a, fv_a;
    logic [EW_A-1:0] err_a;
    logic [AW-1:0] fa_a;
    logic [PW-1:0] fp_a, fg_a;
    logic          busy_b, done_b, to_b, fv_b;
    logic [EW_B-1:0] err_b;
    logic [AW-1:0] fa_b;
    logic [PW-1:0] fp_b, fg_b;

    mult_result_checker_if #(.ADDR_WIDTH(AW), .PROD_WIDTH(PW)) bus_a ();
    mult_result_checker_if #(.ADDR_WIDTH(AW), .PROD_WIDTH(PW)) bus_b ();

    mult_result_checker #(.ADDR_WIDTH(AW), .PROD_WIDTH(PW), .ERR_WIDTH(EW_A), .TIMEOUT(TO)) dut_a (
        .pll_clk(pll_clk), .resetn(resetn), .start(start), .n_vectors(n_vectors), .res(bus_a),
        .busy(busy_a), .done(done_a), .timeout(to_a), .err_count(err_a),
        .first_err_valid(fv_a), .first_err_addr(fa_a), .first_err_prod(fp_a), .first_err_gold(fg_a));

    mult_result_checker #(.ADDR_WIDTH(AW), .PROD_WIDTH(PW), .ERR_WIDTH(EW_B), .TIMEOUT(TO)) dut_b (
        .pll_clk(pll_clk), .resetn(resetn), .start(start), .n_vectors(n_vectors), .res(bus_b),
        .busy(busy_b), .done(done_b), .timeout(to_b), .err_count(err_b),
        .first_err_valid(fv_b), .first_err_addr(fa_b), .first_err_prod(fp_b), .first_err_gold(fg_b));

    initial pll_clk = 1'b0;
    always #5 pll_clk = ~pll_clk;

    // Golden RAM models: registered read, 1-cycle latency.
    logic [PW-1:0] gold_mem [0:(1<<AW)-1];
    always @(posedge pll_clk) begin
        bus_a.gold_q <= gold_mem[bus_a.gold_addr];
        bus_b.gold_q <= gold_mem[bus_b.gold_addr];
    end

    int cyc = 0;
    int done_rise = -1;
    int start_cyc = 0;
    logic done_prev = 1'b0;
    always @(posedge pll_clk) cyc = cyc + 1;
    always @(negedge pll_clk) begin
        if (done_a && !done_prev) done_rise = cyc;
        done_prev = done_a;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] prod;
        logic [PW-1:0] gold;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [AW:0] n_vec;
        int          n_drive;
        logic [15:0] mask;
        int          exp_err_a;
        int          exp_err_b;
        bit          exp_fv;
        int          exp_faddr;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] gold_word(input int i);
        logic [63:0] x;
        x = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
        return x[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] bad_word(input int i);
        return gold_word(i) ^ (PW'(1) << (62 - ((i * 7) % 63)));
    endfunction

    task automatic tick();
        @(posedge pll_clk);
        #1;
    endtask

    task automatic drive_word(input bit v, input int a, input logic [PW-1:0] p);
        bus_a.in_valid = v;
        bus_a.in_addr  = AW'(a);
        bus_a.in_prod  = p;
        bus_b.in_valid = v;
        bus_b.in_addr  = AW'(a);
        bus_b.in_prod  = p;
    endtask

    task automatic pulse_start(input int n);
        tick();
        start     = 1'b1;
        n_vectors = (AW+1)'(n);
        start_cyc = cyc;
        done_rise = -1;
        sb_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_a !== 1'b1 && k < budget) begin
            @(negedge pll_clk);
            k++;
        end
        #1;
        check({tag, "_done"}, 64'(done_a), 64'd1);
    endtask

    // Pops the scoreboard; the first mismatching entry gives the capture words.
    task automatic check_results(input string tag, input int ea, input int eb,
                                 input bit efv, input int efa, input bit eto);
        sb_t e;
        logic [PW-1:0] exp_p = '0;
        logic [PW-1:0] exp_g = '0;
        bit found = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!found && (e.prod !== e.gold)) begin
                found = 1'b1;
                exp_p = e.prod;
                exp_g = e.gold;
            end
        end
        check({tag, "_err_a"},   64'(err_a), 64'(ea));
        check({tag, "_err_b"},   64'(err_b), 64'(eb));
        check({tag, "_fv_a"},    64'(fv_a),  64'(efv));
        check({tag, "_fv_b"},    64'(fv_b),  64'(efv));
        check({tag, "_faddr_a"}, 64'(fa_a),  efv ? 64'(efa) : 64'd0);
        check({tag, "_faddr_b"}, 64'(fa_b),  efv ? 64'(efa) : 64'd0);
        check({tag, "_fprod_a"}, 64'(fp_a),  64'(exp_p));
        check({tag, "_fgold_a"}, 64'(fg_a),  64'(exp_g));
        check({tag, "_fprod_b"}, 64'(fp_b),  64'(exp_p));
        check({tag, "_fgold_b"}, 64'(fg_b),  64'(exp_g));
        check({tag, "_to_a"},    64'(to_a),  64'(eto));
        check({tag, "_to_b"},    64'(to_b),  64'(eto));
        check({tag, "_done_b"},  64'(done_b), 64'd1);
    endtask

    task automatic run_case(input int idx);
        vec_t tc;
        int acc_cyc = 0;
        logic [PW-1:0] p;
        string tag;
        tc  = tbl[idx];
        tag = $sformatf("vec%0d", idx);
        pulse_start(int'(tc.n_vec));
        for (int k = 0; k < tc.n_drive; k++) begin
            tick();
            start = 1'b0;
            p = tc.mask[k] ? bad_word(k) : gold_word(k);
            drive_word(1'b1, k, p);
            if (k < int'(tc.n_vec)) begin
                sb_q.push_back('{AW'(k), p, gold_word(k)});
                acc_cyc = cyc;
            end
        end
        tick();
        start = 1'b0;
        drive_word(1'b0, 0, '0);
        wait_done(tag, 40);
        // FLUSH follows the last accept, DONE the cycle after.
        check({tag, "_latency"}, 64'(done_rise - acc_cyc), 64'd2);
        check_results(tag, tc.exp_err_a, tc.exp_err_b, tc.exp_fv, tc.exp_faddr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [PW-1:0] p;
        int acc_cyc;

        tbl[0] = '{n_vec: 10'd8, n_drive: 8,  mask: 16'h0000, exp_err_a: 0, exp_err_b: 0, exp_fv: 1'b0, exp_faddr: 0};
        tbl[1] = '{n_vec: 10'd8, n_drive: 8,  mask: 16'h0028, exp_err_a: 2, exp_err_b: 2, exp_fv: 1'b1, exp_faddr: 3};
        tbl[2] = '{n_vec: 10'd6, n_drive: 6,  mask: 16'h003F, exp_err_a: 6, exp_err_b: 3, exp_fv: 1'b1, exp_faddr: 0};
        tbl[3] = '{n_vec: 10'd8, n_drive: 10, mask: 16'h0300, exp_err_a: 0, exp_err_b: 0, exp_fv: 1'b0, exp_faddr: 0};
        tbl[4] = '{n_vec: 10'd3, n_drive: 3,  mask: 16'h0004, exp_err_a: 1, exp_err_b: 1, exp_fv: 1'b1, exp_faddr: 2};

        for (int i = 0; i < (1 << AW); i++) gold_mem[i] = gold_word(i);

        resetn    = 1'b0;
        start     = 1'b0;
        n_vectors = '0;
        drive_word(1'b0, 0, '0);
        repeat (3) tick();
        @(negedge pll_clk);
        check("rst_busy",  64'(busy_a), 64'd0);
        check("rst_done",  64'(done_a), 64'd0);
        check("rst_to",    64'(to_a),   64'd0);
        check("rst_err",   64'(err_a),  64'd0);
        check("rst_fv",    64'(fv_a),   64'd0);
        check("rst_busy_b", 64'(busy_b), 64'd0);
        tick();
        resetn = 1'b1;

        // in_valid while IDLE must not be compared or counted.
        tick(); drive_word(1'b1, 0, bad_word(0));
        tick(); drive_word(1'b1, 1, bad_word(1));
        tick(); drive_word(1'b0, 0, '0);
        @(negedge pll_clk);
        check("idle_err",  64'(err_a),  64'd0);
        check("idle_busy", 64'(busy_a), 64'd0);

        for (int i = 0; i < 5; i++) run_case(i);

        // Mid-run start ignored; in_valid in DONE before start ignored.
        for (int k = 0; k < 3; k++) begin
            tick();
            drive_word(1'b1, k, bad_word(k));
        end
        pulse_start(8);
        acc_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            start     = (k == 3);
            n_vectors = (k == 3) ? 10'd2 : 10'd8;
            p = (k == 1) ? bad_word(k) : gold_word(k);
            drive_word(1'b1, k, p);
            sb_q.push_back('{AW'(k), p, gold_word(k)});
            acc_cyc = cyc;
        end
        tick();
        start = 1'b0;
        drive_word(1'b0, 0, '0);
        wait_done("midstart", 40);
        check("midstart_latency", 64'(done_rise - acc_cyc), 64'd2);
        check_results("midstart", 1, 1, 1'b1, 1, 1'b0);

        // n_vectors == 0: one RUN cycle, one FLUSH cycle, then DONE.
        pulse_start(0);
        drive_word(1'b1, 0, bad_word(0));
        tick();
        start = 1'b0;
        @(negedge pll_clk);
        check("nvec0_busy1", 64'({busy_a, done_a}), 64'b10);
        tick();
        @(negedge pll_clk);
        check("nvec0_busy2", 64'({busy_a, done_a}), 64'b10);
        wait_done("nvec0", 10);
        drive_word(1'b0, 0, '0);
        check("nvec0_latency", 64'(done_rise - start_cyc), 64'd3);
        check_results("nvec0", 0, 0, 1'b0, 0, 1'b0);

        // Watchdog: only 2 of 4 products arrive.
        pulse_start(4);
        tick();
        start = 1'b0;
        p = gold_word(0);
        drive_word(1'b1, 0, p);
        sb_q.push_back('{AW'(0), p, gold_word(0)});
        tick();
        p = bad_word(1);
        drive_word(1'b1, 1, p);
        sb_q.push_back('{AW'(1), p, gold_word(1)});
        acc_cyc = cyc;
        tick();
        drive_word(1'b0, 0, '0);
        wait_done("wdog", 60);
        // TIMEOUT idle RUN cycles, then FLUSH, then DONE.
        check("wdog_latency", 64'(done_rise - acc_cyc), 64'(TO + 2));
        check_results("wdog", 1, 1, 1'b1, 1, 1'b1);

        // Reset mid-run with a compare in flight.
        pulse_start(8);
        for (int k = 0; k < 4; k++) begin
            tick();
            start = 1'b0;
            drive_word(1'b1, k, bad_word(k));
        end
        @(negedge pll_clk);
        check("mrst_pre_fv", 64'(fv_a), 64'd1);
        tick();
        resetn = 1'b0;
        drive_word(1'b1, 4, bad_word(4));
        tick();
        resetn = 1'b1;
        drive_word(1'b0, 0, '0);
        @(negedge pll_clk);
        check("mrst_busy",  64'(busy_a), 64'd0);
        check("mrst_done",  64'(done_a), 64'd0);
        check("mrst_to",    64'(to_a),   64'd0);
        check("mrst_err",   64'(err_a),  64'd0);
        check("mrst_fv",    64'(fv_a),   64'd0);
        check("mrst_faddr", 64'(fa_a),   64'd0);
        check("mrst_fprod", 64'(fp_a),   64'd0);
        check("mrst_fgold", 64'(fg_a),   64'd0);
        repeat (3) tick();
        @(negedge pll_clk);
        check("mrst_post_err", 64'(err_a), 64'd0);
        check("mrst_post_fv",  64'(fv_a),  64'd0);
        sb_q.delete();
        run_case(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
